product_accumulator: RTL and testbench

- Downstream consumer of the 32x32 sequential shift-add multiplier.
- Captures each 64-bit unsigned Product on the multiplier's one-cycle Product_Valid pulse and accumulates N_ACC consecutive products into a wide sum.
- Presents the completed sum on a valid/ready handshake.
- A one-entry skid buffer absorbs a product that arrives while the output is stalled.

---
 rtl/product_accumulator.sv | 185 ++++++++++++++++++
 tb/tb_product_accumulator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sits after the 32x32 sequential shift-add multiplier. It captures each 64-bit
// unsigned Product on its one-cycle Product_Valid strobe and adds N_ACC
// consecutive products into an ACC_W-bit sum. The finished sum is offered on a
// valid/ready handshake. While a sum waits for the consumer (HOLD), one
// arriving product is parked in a skid register. Any further arrival is
// discarded and flagged on Drop.
//
// Parameters
//   N_ACC  products per sum, 1..255
//   ACC_W  accumulator / Sum width, >= 64
//
// Ports
//   CLK            rising-edge clock
//   RST_N          asynchronous active-low reset
//   Product        multiplier result, unsigned, valid with Product_Valid
//   Product_Valid  single-cycle strobe
//   Clear          synchronous abort of the running accumulation; a pending
//                  sum and its handshake are left alone
//   Sum            last completed sum; holds its value after delivery
//   Sum_Valid      Sum is offered; held until Sum_Ready is seen
//   Sum_Ready      consumer accepts Sum when Sum_Valid is also high
//   Acc_Count      products folded into the running accumulation
//   Overflow       sticky; an add carried out of bit ACC_W-1
//   Drop           sticky; a product arrived while the skid was occupied
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int N_ACC = 4,
  parameter int ACC_W = 72
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [63:0]      Product,
  input  logic             Product_Valid,
  input  logic             Clear,
  output logic [ACC_W-1:0] Sum,
  output logic             Sum_Valid,
  input  logic             Sum_Ready,
  output logic [7:0]       Acc_Count,
  output logic             Overflow,
  output logic             Drop
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_d;
  logic             sum_valid_d;
  logic [7:0]       cnt_d;
  logic             ovf_d, drop_d;
  logic [63:0]      skid_q, skid_d;
  logic             skid_full_q, skid_full_d;

  logic             add_en;
  logic [63:0]      add_val;
  logic [ACC_W:0]   add_sum;   // extra top bit is the carry out
  logic [7:0]       cnt_inc;
  logic             last_add;
  logic             handshake;

  assign handshake = Sum_Valid & Sum_Ready;
  assign add_sum   = {1'b0, acc_q} + {{(ACC_W + 1 - 64){1'b0}}, add_val};
  assign cnt_inc   = Acc_Count + 8'd1;
  assign last_add  = (cnt_inc == 8'(N_ACC));

  // Adder operand select. The skid entry is older than anything arriving now,
  // so it always wins; a fresh product in that cycle refills the skid.
  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    add_en  = 1'b0;
    add_val = skid_q;
    if (!Clear && state_q == ACCUM) begin
      if (skid_full_q) begin
        add_en  = 1'b1;
        add_val = skid_q;
      end else if (Product_Valid) begin
        add_en  = 1'b1;
        add_val = Product;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = Sum;
    sum_valid_d = Sum_Valid;
    cnt_d       = Acc_Count;
    ovf_d       = Overflow;
    drop_d      = Drop;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;

    if (Clear) begin
      // Abort the accumulation but keep an offered sum so the consumer still
      // sees a clean handshake. The concurrent product is discarded.
      acc_d       = '0;
      cnt_d       = '0;
      skid_full_d = 1'b0;
      ovf_d       = 1'b0;
      drop_d      = 1'b0;
      if (handshake) begin
        sum_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (skid_full_q) begin
            skid_full_d = Product_Valid;
            if (Product_Valid) skid_d = Product;
          end
          if (add_en) begin
            ovf_d = Overflow | add_sum[ACC_W];
            if (last_add) begin
              sum_d       = add_sum[ACC_W-1:0];
              sum_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = HOLD;
            end else begin
              acc_d = add_sum[ACC_W-1:0];
              cnt_d = cnt_inc;
            end
          end
        end

        HOLD: begin
          // An arrival in the handshake cycle itself is still a HOLD arrival.
          if (Product_Valid) begin
            if (!skid_full_q) begin
              skid_d      = Product;
              skid_full_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
          if (handshake) begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end

        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      Sum         <= '0;
      Sum_Valid   <= 1'b0;
      Acc_Count   <= '0;
      Overflow    <= 1'b0;
      Drop        <= 1'b0;
      // NOTE: the skid data register is reset along with its flag; it is a
      // single word, so this costs nothing and keeps it free of X after reset.
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      Sum         <= sum_d;
      Sum_Valid   <= sum_valid_d;
      Acc_Count   <= cnt_d;
      Overflow    <= ovf_d;
      Drop        <= drop_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Three instances share one stimulus stream:
//   dut0: N_ACC=4, ACC_W=72
//   dut1: N_ACC=1, ACC_W=72  (exercises the skid buffer and Drop)
//   dut2: N_ACC=4, ACC_W=64  (exercises Overflow)
// A reference model per instance tracks the documented behaviour. It pushes
// each completed sum into an expectation ring. A negedge monitor pops that
// ring whenever a handshake is presented, and it compares the status outputs.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] Product;
  logic        Product_Valid;
  logic        Clear;
  logic        Sum_Ready;

  logic [71:0] sum0, sum1;
  logic [63:0] sum2;
  logic        sv0, sv1, sv2;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        ovf0, ovf1, ovf2;
  logic        drp0, drp1, drp2;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  product_accumulator #(.N_ACC(4), .ACC_W(72)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .Product(Product), .Product_Valid(Product_Valid),
    .Clear(Clear), .Sum(sum0), .Sum_Valid(sv0), .Sum_Ready(Sum_Ready),
    .Acc_Count(cnt0), .Overflow(ovf0), .Drop(drp0));

  product_accumulator #(.N_ACC(1), .ACC_W(72)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .Product(Product), .Product_Valid(Product_Valid),
    .Clear(Clear), .Sum(sum1), .Sum_Valid(sv1), .Sum_Ready(Sum_Ready),
    .Acc_Count(cnt1), .Overflow(ovf1), .Drop(drp1));

  product_accumulator #(.N_ACC(4), .ACC_W(64)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .Product(Product), .Product_Valid(Product_Valid),
    .Clear(Clear), .Sum(sum2), .Sum_Valid(sv2), .Sum_Ready(Sum_Ready),
    .Acc_Count(cnt2), .Overflow(ovf2), .Drop(drp2));

  always #5 CLK = ~CLK;

  // Uniform views of the three instances.
  logic [71:0] sum_a [3];
  logic        sv_a  [3];
  logic [7:0]  cnt_a [3];
  logic        ovf_a [3];
  logic        drp_a [3];

  always_comb begin
    sum_a[0] = sum0;  sum_a[1] = sum1;  sum_a[2] = {8'b0, sum2};
    sv_a[0]  = sv0;   sv_a[1]  = sv1;   sv_a[2]  = sv2;
    cnt_a[0] = cnt0;  cnt_a[1] = cnt1;  cnt_a[2] = cnt2;
    ovf_a[0] = ovf0;  ovf_a[1] = ovf1;  ovf_a[2] = ovf2;
    drp_a[0] = drp0;  drp_a[1] = drp1;  drp_a[2] = drp2;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int nacc_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int accw_of(input int i);
    return (i == 2) ? 64 : 72;
  endfunction

  logic [71:0] m_acc  [3];
  logic [71:0] m_sum  [3];
  int          m_cnt  [3];
  bit          m_busy [3];   // a completed sum is waiting for the consumer
  bit          m_pfull[3];   // one product parked while busy
  logic [63:0] m_pend [3];
  bit          m_ovf  [3];
  bit          m_drop [3];
  logic [71:0] exp_mem[3][64];
  int          wr_ptr [3];
  int          rd_ptr [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0;  m_sum[i] = '0;  m_cnt[i] = 0;  m_busy[i] = 1'b0;
      m_pfull[i] = 1'b0;  m_pend[i] = '0;  m_ovf[i] = 1'b0;  m_drop[i] = 1'b0;
      wr_ptr[i] = 0;  rd_ptr[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit pv, input logic [63:0] p,
                            input bit clr, input bit rdy);
    bit          accepted;
    bit          have;
    logic [63:0] v;
    logic [72:0] s;
    accepted = m_busy[i] && rdy;
    have     = 1'b0;
    v        = '0;
    if (clr) begin
      m_acc[i] = '0;  m_cnt[i] = 0;  m_pfull[i] = 1'b0;
      m_ovf[i] = 1'b0;  m_drop[i] = 1'b0;
      if (accepted) m_busy[i] = 1'b0;
    end else if (!m_busy[i]) begin
      // Oldest product first: a parked product beats a fresh arrival, which
      // then takes its place.
      if (m_pfull[i]) begin
        have = 1'b1;  v = m_pend[i];
        m_pfull[i] = pv;
        if (pv) m_pend[i] = p;
      end else if (pv) begin
        have = 1'b1;  v = p;
      end
      if (have) begin
        s = {1'b0, m_acc[i]} + {9'b0, v};
        if (accw_of(i) == 64) begin
          if (s[64]) m_ovf[i] = 1'b1;
          s[64] = 1'b0;
        end else if (s[72]) begin
          m_ovf[i] = 1'b1;
        end
        m_acc[i] = s[71:0];
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == nacc_of(i)) begin
          m_sum[i] = m_acc[i];
          exp_mem[i][wr_ptr[i] % 64] = m_acc[i];
          wr_ptr[i]++;
          m_busy[i] = 1'b1;
          m_acc[i]  = '0;
          m_cnt[i]  = 0;
        end
      end
    end else begin
      if (pv) begin
        if (!m_pfull[i]) begin
          m_pfull[i] = 1'b1;  m_pend[i] = p;
        end else begin
          m_drop[i] = 1'b1;
        end
      end
      if (accepted) m_busy[i] = 1'b0;
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i, Product_Valid, Product, Clear, Sum_Ready);
  end

  // ---------------------------------------------------------------------------
  // Monitor: status every cycle, scoreboard pop on each handshake
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sum_valid[%0d]", i), {71'b0, sv_a[i]}, {71'b0, m_busy[i]});
      check($sformatf("acc_count[%0d]", i), {64'b0, cnt_a[i]}, 72'(m_cnt[i]));
      check($sformatf("overflow[%0d]", i), {71'b0, ovf_a[i]}, {71'b0, m_ovf[i]});
      check($sformatf("drop[%0d]", i), {71'b0, drp_a[i]}, {71'b0, m_drop[i]});
      check($sformatf("sum_hold[%0d]", i), sum_a[i], m_sum[i]);
      if (RST_N && sv_a[i] && Sum_Ready) begin
        if (rd_ptr[i] == wr_ptr[i]) begin
          check($sformatf("unexpected_sum[%0d]", i), sum_a[i], 72'hx);
        end else begin
          check($sformatf("scoreboard_sum[%0d]", i), sum_a[i], exp_mem[i][rd_ptr[i] % 64]);
          rd_ptr[i]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change 1 time unit after each rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit pv, input logic [63:0] p, input bit clr);
    Product_Valid = pv;
    Product       = p;
    Clear         = clr;
    @(posedge CLK);
    #1;
    Product_Valid = 1'b0;
    Clear         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    RST_N         = 1'b0;
    Product       = '0;
    Product_Valid = 1'b0;
    Clear         = 1'b0;
    Sum_Ready     = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_sum0", sum0, 72'd0);
    check("reset_sum_valid0", {71'b0, sv0}, 72'd0);
    check("reset_acc_count0", {64'b0, cnt0}, 72'd0);
    check("reset_overflow2", {71'b0, ovf2}, 72'd0);
    check("reset_drop1", {71'b0, drp1}, 72'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(2);

    // Basic sum: 1+2+3+4 with the consumer always ready.
    Sum_Ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 64'(k), 1'b0);
      if (k < 4) begin
        check($sformatf("basic_count_%0d", k), {64'b0, cnt0}, 72'(k));
        check($sformatf("basic_no_valid_%0d", k), {71'b0, sv0}, 72'd0);
        idle(33);
      end
    end
    check("basic_sum", sum0, 72'd10);
    check("basic_valid", {71'b0, sv0}, 72'd1);
    check("basic_count_wrap", {64'b0, cnt0}, 72'd0);
    idle(1);
    check("basic_valid_one_cycle", {71'b0, sv0}, 72'd0);
    idle(3);

    // Width and overflow: four all-ones products.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, ALL_ONES, 1'b0);
      if (k < 3) idle(3);
    end
    check("wide_sum", sum0, 72'h3_FFFF_FFFF_FFFF_FFFC);
    check("wide_no_overflow", {71'b0, ovf0}, 72'd0);
    check("narrow_sum", {8'b0, sum2}, 72'h0_FFFF_FFFF_FFFF_FFFC);
    check("narrow_overflow", {71'b0, ovf2}, 72'd1);
    idle(4);
    check("narrow_overflow_sticky", {71'b0, ovf2}, 72'd1);
    cyc(1'b0, 64'd0, 1'b1);
    check("clear_overflow", {71'b0, ovf2}, 72'd0);
    idle(3);

    // Back-pressure: the second product waits in the skid.
    Sum_Ready = 1'b0;
    cyc(1'b1, 64'd5, 1'b0);
    idle(1);
    cyc(1'b1, 64'd7, 1'b0);
    idle(2);
    check("skid_held_sum", sum1, 72'd5);
    check("skid_held_valid", {71'b0, sv1}, 72'd1);
    Sum_Ready = 1'b1;
    idle(2);
    check("skid_second_sum", sum1, 72'd7);
    check("skid_no_drop", {71'b0, drp1}, 72'd0);
    idle(4);

    // Drop: a third product while both the output and the skid are full.
    Sum_Ready = 1'b0;
    cyc(1'b1, 64'd5, 1'b0);
    idle(1);
    cyc(1'b1, 64'd7, 1'b0);
    idle(1);
    cyc(1'b1, 64'd9, 1'b0);
    idle(1);
    check("drop_set", {71'b0, drp1}, 72'd1);
    Sum_Ready = 1'b1;
    idle(8);

    // Clear mid-accumulation.
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b1, 64'd100, 1'b0);
    idle(2);
    cyc(1'b1, 64'd200, 1'b0);
    idle(2);
    cyc(1'b0, 64'd0, 1'b1);
    check("clear_count", {64'b0, cnt0}, 72'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 64'(k), 1'b0);
      if (k < 4) idle(2);
    end
    check("clear_then_sum", sum0, 72'd10);
    idle(4);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [63:0] p;
      if (k % 200 < 40) Sum_Ready = ($urandom_range(0, 3) == 0);
      else Sum_Ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) p = ALL_ONES;
      else p = {$urandom, $urandom};
      cyc(($urandom_range(0, 2) == 0), p, ($urandom_range(0, 99) == 0));
    end

    // Drain and confirm every expected sum was delivered.
    Sum_Ready = 1'b1;
    idle(20);
    for (int i = 0; i < 3; i++)
      check($sformatf("scoreboard_empty[%0d]", i), 72'(wr_ptr[i] - rd_ptr[i]), 72'd0);

    // Asynchronous reset with dut0 mid-accumulation and dut1 holding a sum.
    Sum_Ready = 1'b0;
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b1, 64'd5, 1'b0);
    idle(1);
    cyc(1'b1, 64'd7, 1'b0);
    idle(1);
    check("pre_reset_count0", {64'b0, cnt0}, 72'd2);
    check("pre_reset_valid1", {71'b0, sv1}, 72'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_count0", {64'b0, cnt0}, 72'd0);
    check("async_valid1", {71'b0, sv1}, 72'd0);
    check("async_sum1", sum1, 72'd0);
    check("async_sum0", sum0, 72'd0);
    check("async_sum2", {8'b0, sum2}, 72'd0);
    check("async_flags", {66'b0, ovf0, ovf1, ovf2, drp0, drp1, drp2}, 72'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    Sum_Ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
